// File: rtl/inst_encode.sv
// inst_encode: packs decoded RV32I fields into a 32-bit instruction word.
// Input and output use valid/ready; results pass through a registered two-entry buffer.
module inst_encode #(
  parameter int CNT_W     = 16,
  parameter bit CHECK_IMM = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fmt,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      inst,
  output logic             invalid,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  // True when the bits selected by mask are all copies of one sign bit.
  function automatic logic sext_fits(input logic [31:0] v, input logic [31:0] mask);
    return ((v & mask) == 32'd0) || ((v & mask) == mask);
  endfunction

  function automatic logic imm_legal(input logic [2:0] f, input logic [31:0] v);
    logic ok;
    case (f)
      FMT_R:        ok = 1'b1;
      FMT_I, FMT_S: ok = sext_fits(v, 32'hFFFF_F800);
      FMT_B:        ok = sext_fits(v, 32'hFFFF_F000) && !v[0];
      FMT_U:        ok = (v[11:0] == 12'd0);
      FMT_J:        ok = sext_fits(v, 32'hFFF0_0000) && !v[0];
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] pack_word(
    input logic [2:0]  f,
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  d,
    input logic [4:0]  s1,
    input logic [4:0]  s2,
    input logic [31:0] v
  );
    logic [31:0] w;
    case (f)
      FMT_R:   w = {f7, s2, s1, f3, d, op};
      FMT_I:   w = {v[11:0], s1, f3, d, op};
      FMT_S:   w = {v[11:5], s2, s1, f3, v[4:0], op};
      FMT_B:   w = {v[12], v[10:5], s2, s1, f3, v[4:1], v[11], op};
      FMT_U:   w = {v[31:12], d, op};
      FMT_J:   w = {v[20], v[10:1], v[11], v[19:12], d, op};
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  buf_state_t       state_r, next_state_s;
  logic             in_ready_r, out_valid_r;
  logic [31:0]      inst_r, skid_inst_r, enc_inst_s;
  logic             invalid_r, skid_invalid_r, enc_bad_s;
  logic [CNT_W-1:0] err_count_r;
  logic             in_xfer_s, out_xfer_s;
  logic             load_out_s, load_skid_s, move_skid_s;

  assign in_xfer_s  = in_valid & in_ready_r;
  assign out_xfer_s = out_valid_r & out_ready;

  // Encode the offered bundle; illegal bundles yield a zero word.
  always_comb begin
    enc_bad_s = 1'b0;
    if (fmt > FMT_J) begin
      enc_bad_s = 1'b1;
    end else if (opcode[1:0] != 2'b11) begin
      enc_bad_s = 1'b1;
    end else if (CHECK_IMM && !imm_legal(fmt, imm)) begin
      enc_bad_s = 1'b1;
    end else begin
      enc_bad_s = 1'b0;
    end
    if (enc_bad_s) begin
      enc_inst_s = 32'd0;
    end else begin
      enc_inst_s = pack_word(fmt, opcode, funct3, funct7, rd, rs1, rs2, imm);
    end
  end

  // Buffer occupancy transitions and the load strobes they imply.
  always_comb begin
    next_state_s = state_r;
    load_out_s   = 1'b0;
    load_skid_s  = 1'b0;
    move_skid_s  = 1'b0;
    case (state_r)
      EMPTY: begin
        if (in_xfer_s) begin
          next_state_s = ONE;
          load_out_s   = 1'b1;
        end else begin
          next_state_s = EMPTY;
        end
      end
      ONE: begin
        if (in_xfer_s && out_xfer_s) begin
          next_state_s = ONE;
          load_out_s   = 1'b1;
        end else if (in_xfer_s) begin
          next_state_s = TWO;
          load_skid_s  = 1'b1;
        end else if (out_xfer_s) begin
          next_state_s = EMPTY;
        end else begin
          next_state_s = ONE;
        end
      end
      TWO: begin
        if (out_xfer_s) begin
          next_state_s = ONE;
          move_skid_s  = 1'b1;
        end else begin
          next_state_s = TWO;
        end
      end
      default: next_state_s = EMPTY;
    endcase
  end

  // State plus registered handshake flags, so in_ready never sees out_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= next_state_s;
      out_valid_r <= (next_state_s != EMPTY);
      in_ready_r  <= (next_state_s != TWO);
    end
  end

  // Output register and skid entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_r         <= 32'd0;
      invalid_r      <= 1'b0;
      skid_inst_r    <= 32'd0;
      skid_invalid_r <= 1'b0;
    end else begin
      if (load_out_s) begin
        inst_r    <= enc_inst_s;
        invalid_r <= enc_bad_s;
      end else if (move_skid_s) begin
        inst_r    <= skid_inst_r;
        invalid_r <= skid_invalid_r;
      end
      if (load_skid_s) begin
        skid_inst_r    <= enc_inst_s;
        skid_invalid_r <= enc_bad_s;
      end
    end
  end

  // Count delivered invalid results, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_r <= {CNT_W{1'b0}};
    end else if (out_xfer_s && invalid_r && (err_count_r != {CNT_W{1'b1}})) begin
      err_count_r <= err_count_r + CNT_W'(1);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign inst      = inst_r;
  assign invalid   = invalid_r;
  assign err_count = err_count_r;

endmodule
